// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake state, word type and the arbiter's
// grant/FSM encodings.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

   typedef enum logic [1:0] {NONE, IRD, DRD, DWR} arb_kind_t;

   typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

   localparam word_t ARB_ERR_WORD = 32'hBAD1BAD1;

   // Index width for a core number; a single core still needs one bit.
   function automatic int core_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-miss ports of every core plus the single shared RAM port, as seen by
// the arbiter (master) and by the cores/RAM model (slave).
interface mem_arbiter_if import cpu_types_pkg::*; #(parameter int CPUS = 2);

   // Handshake: a core raises xREN/dWEN with a stable address (and store data)
   // and holds it while its wait bit is 1; the request is complete in the one
   // cycle where wait is 0, and that cycle's load bus carries the read data.
   // Dropping a request before completion aborts it silently.
   logic [CPUS-1:0]    iREN;
   logic [CPUS*32-1:0] iaddr;
   logic [CPUS-1:0]    iwait;
   logic [CPUS*32-1:0] iload;
   logic [CPUS-1:0]    dREN;
   logic [CPUS-1:0]    dWEN;
   logic [CPUS*32-1:0] daddr;
   logic [CPUS*32-1:0] dstore;
   logic [CPUS-1:0]    dwait;
   logic [CPUS*32-1:0] dload;

   logic               ramREN;
   logic               ramWEN;
   word_t              ramaddr;
   word_t              ramstore;
   word_t              ramload;
   ramstate_t          ramstate;

   modport master (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );

   modport slave (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin selector: first requesting core at or after ptr,
// wrapping modulo CPUS.
module rr_pick #(
   parameter int CPUS = 2,
   parameter int IW   = 1
) (
   input  logic [CPUS-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic            valid,
   output logic [IW-1:0]   winner
);

   int idx;

   always_comb begin
      valid  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int i = 0; i < CPUS; i++) begin
         idx = (int'(ptr) + i) % CPUS;
         if (!valid && req[idx]) begin
            valid  = 1'b1;
            winner = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Multicore RAM arbiter: one transaction at a time, round-robin across cores,
// data before instruction inside a core, write before read.
module mem_arbiter import cpu_types_pkg::*; #(
   parameter int  CPUS      = 2,
   parameter bit  ERR_RETRY = 1'b1,
   localparam int IW        = core_idx_w(CPUS)
) (
   input  logic          CLK,
   input  logic          nRST,
   mem_arbiter_if.master bus,
   output arb_state_t    dbg_state,
   output logic [IW-1:0] dbg_rr_ptr,
   output logic [IW-1:0] dbg_gnt_core,
   output arb_kind_t     dbg_gnt_kind
);

   arb_state_t      state;
   arb_kind_t       gnt_kind;
   logic [IW-1:0]   gnt_core;
   logic [IW-1:0]   rr_ptr;
   word_t           iload_q [CPUS];
   word_t           dload_q [CPUS];

   logic [CPUS-1:0] core_req;
   logic            pick_valid;
   logic [IW-1:0]   pick_core;
   logic            gnt_active;
   logic            done;
   word_t           done_word;

   assign core_req = bus.iREN | bus.dREN | bus.dWEN;

   rr_pick #(.CPUS(CPUS), .IW(IW)) u_pick (
      .req    (core_req),
      .ptr    (rr_ptr),
      .valid  (pick_valid),
      .winner (pick_core)
   );

   // gnt_active low in GRANT means the requester withdrew: abort, no completion.
   always_comb begin
      gnt_active = 1'b0;
      if (state == ARB_GRANT) begin
         case (gnt_kind)
            IRD:     gnt_active = bus.iREN[gnt_core];
            DRD:     gnt_active = bus.dREN[gnt_core];
            DWR:     gnt_active = bus.dWEN[gnt_core];
            default: gnt_active = 1'b0;
         endcase
      end
      done      = gnt_active &&
                  ((bus.ramstate == ACCESS) || ((bus.ramstate == ERROR) && !ERR_RETRY));
      done_word = (bus.ramstate == ACCESS) ? bus.ramload : ARB_ERR_WORD;
   end

   always_comb begin
      bus.ramREN   = gnt_active && (gnt_kind != DWR);
      bus.ramWEN   = gnt_active && (gnt_kind == DWR);
      bus.ramaddr  = '0;
      bus.ramstore = '0;
      if (gnt_active) begin
         bus.ramaddr = (gnt_kind == IRD) ? bus.iaddr[32*gnt_core +: 32]
                                         : bus.daddr[32*gnt_core +: 32];
         if (gnt_kind == DWR) bus.ramstore = bus.dstore[32*gnt_core +: 32];
      end
   end

   // Waits follow the request lines; only the completing requester sees 0.
   always_comb begin
      bus.iwait = bus.iREN;
      bus.dwait = bus.dREN | bus.dWEN;
      bus.iload = '0;
      bus.dload = '0;
      for (int c = 0; c < CPUS; c++) begin
         bus.iload[32*c +: 32] = iload_q[c];
         bus.dload[32*c +: 32] = dload_q[c];
         if (done && (gnt_core == IW'(c))) begin
            if (gnt_kind == IRD) begin
               bus.iwait[c]          = 1'b0;
               bus.iload[32*c +: 32] = done_word;
            end else begin
               bus.dwait[c] = 1'b0;
               if (gnt_kind == DRD) bus.dload[32*c +: 32] = done_word;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state    <= ARB_IDLE;
         gnt_core <= '0;
         gnt_kind <= NONE;
         rr_ptr   <= '0;
         for (int c = 0; c < CPUS; c++) begin
            iload_q[c] <= '0;
            dload_q[c] <= '0;
         end
      end else begin
         case (state)
            ARB_IDLE: begin
               if (pick_valid) begin
                  state    <= ARB_GRANT;
                  gnt_core <= pick_core;
                  if (bus.dWEN[pick_core])      gnt_kind <= DWR;
                  else if (bus.dREN[pick_core]) gnt_kind <= DRD;
                  else                          gnt_kind <= IRD;
               end
            end
            ARB_GRANT: begin
               if (!gnt_active) begin
                  state    <= ARB_IDLE;
                  gnt_kind <= NONE;
               end else if (done) begin
                  state    <= ARB_IDLE;
                  gnt_kind <= NONE;
                  rr_ptr   <= IW'((int'(gnt_core) + 1) % CPUS);
                  if (gnt_kind == IRD)      iload_q[gnt_core] <= done_word;
                  else if (gnt_kind == DRD) dload_q[gnt_core] <= done_word;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   assign dbg_state    = state;
   assign dbg_rr_ptr   = rr_ptr;
   assign dbg_gnt_core = gnt_core;
   assign dbg_gnt_kind = gnt_kind;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios on two instances (retry / no-retry)
// plus a randomized run against a transaction-level reference model.
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if #(.CPUS(2)) b1 ();
   mem_arbiter_if #(.CPUS(2)) b2 ();

   arb_state_t st1, st2;
   arb_kind_t  k1, k2;
   logic [0:0] r1, r2, gc1, gc2;

   mem_arbiter #(.CPUS(2), .ERR_RETRY(1'b1)) u_dut1 (
      .CLK(clk), .nRST(rst_n), .bus(b1),
      .dbg_state(st1), .dbg_rr_ptr(r1), .dbg_gnt_core(gc1), .dbg_gnt_kind(k1)
   );

   mem_arbiter #(.CPUS(2), .ERR_RETRY(1'b0)) u_dut2 (
      .CLK(clk), .nRST(rst_n), .bus(b2),
      .dbg_state(st2), .dbg_rr_ptr(r2), .dbg_gnt_core(gc2), .dbg_gnt_kind(k2)
   );

   int total = 0;
   int bad = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_dl0, exp_dl1;

   // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      b1.iREN = '0; b1.iaddr = '0; b1.dREN = '0; b1.dWEN = '0;
      b1.daddr = '0; b1.dstore = '0; b1.ramload = '0; b1.ramstate = FREE;
      b2.iREN = '0; b2.iaddr = '0; b2.dREN = '0; b2.dWEN = '0;
      b2.daddr = '0; b2.dstore = '0; b2.ramload = '0; b2.ramstate = FREE;
   endtask

   function automatic int pick(input int ptr, input logic [1:0] req);
      for (int i = 0; i < 2; i++) begin
         int c;
         c = (ptr + i) % 2;
         if (req[c]) return c;
      end
      return -1;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      b1.iREN = 2'b01;
      b1.dREN = 2'b10;
      #3;
      total++; if (b1.iwait !== 2'b01) begin bad++; $display("FAIL reset_iwait: got %b exp %b", b1.iwait, 2'b01); end
      total++; if (b1.dwait !== 2'b10) begin bad++; $display("FAIL reset_dwait: got %b exp %b", b1.dwait, 2'b10); end
      total++; if (b1.ramREN !== 1'b0 || b1.ramWEN !== 1'b0) begin bad++; $display("FAIL reset_en: got %b%b exp 00", b1.ramREN, b1.ramWEN); end
      total++; if (b1.ramaddr !== 32'h0 || b1.ramstore !== 32'h0) begin bad++; $display("FAIL reset_ram_bus: got %h/%h exp 0/0", b1.ramaddr, b1.ramstore); end
      total++; if (b1.iload !== 64'h0 || b1.dload !== 64'h0) begin bad++; $display("FAIL reset_loads: got %h/%h exp 0/0", b1.iload, b1.dload); end
      total++; if (st1 !== ARB_IDLE || r1 !== 1'b0 || k1 !== NONE || gc1 !== 1'b0) begin bad++; $display("FAIL reset_regs: got st=%0d rr=%0d kind=%0d gc=%0d exp 0 0 0 0", st1, r1, k1, gc1); end
      @(posedge clk);
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single_fetch();
      cyc(); b1.iREN = 2'b01; b1.iaddr[31:0] = 32'h40; b1.ramstate = FREE;
      smp();
      total++; if (b1.iwait !== 2'b01 || b1.ramREN !== 1'b0) begin bad++; $display("FAIL fetch_idle: got wait=%b ren=%b exp 01 0", b1.iwait, b1.ramREN); end
      cyc(); b1.ramstate = BUSY;
      smp();
      total++; if (b1.ramREN !== 1'b1 || b1.ramaddr !== 32'h40) begin bad++; $display("FAIL fetch_drive: got ren=%b addr=%h exp 1 40", b1.ramREN, b1.ramaddr); end
      total++; if (b1.iwait !== 2'b01) begin bad++; $display("FAIL fetch_busy_wait: got %b exp 01", b1.iwait); end
      cyc(); b1.ramstate = ACCESS; b1.ramload = 32'h3C010001;
      smp();
      total++; if (b1.iwait !== 2'b00) begin bad++; $display("FAIL fetch_done_wait: got %b exp 00", b1.iwait); end
      total++; if (b1.iload[31:0] !== 32'h3C010001) begin bad++; $display("FAIL fetch_load: got %h exp 3c010001", b1.iload[31:0]); end
      cyc(); b1.iREN = 2'b00; b1.ramstate = FREE; b1.ramload = 32'h0;
      smp();
      total++; if (st1 !== ARB_IDLE || b1.ramREN !== 1'b0) begin bad++; $display("FAIL fetch_after: got st=%0d ren=%b exp 0 0", st1, b1.ramREN); end
      total++; if (b1.iload[31:0] !== 32'h3C010001 || r1 !== 1'b1) begin bad++; $display("FAIL fetch_hold: got load=%h rr=%0d exp 3c010001 1", b1.iload[31:0], r1); end
   endtask

   task automatic test_write_priority();
      cyc(); b1.iREN = 2'b01; b1.iaddr[31:0] = 32'h44;
      b1.dWEN = 2'b01; b1.daddr[31:0] = 32'h80; b1.dstore[31:0] = 32'hDEADBEEF;
      b1.ramstate = ACCESS; b1.ramload = 32'hAAAA0000;
      smp();
      total++; if (b1.ramREN !== 1'b0 || b1.ramWEN !== 1'b0) begin bad++; $display("FAIL wr_idle_en: got %b%b exp 00", b1.ramREN, b1.ramWEN); end
      cyc();
      smp();
      total++; if (b1.ramWEN !== 1'b1 || b1.ramREN !== 1'b0) begin bad++; $display("FAIL wr_en: got wen=%b ren=%b exp 1 0", b1.ramWEN, b1.ramREN); end
      total++; if (b1.ramaddr !== 32'h80 || b1.ramstore !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_bus: got %h/%h exp 80/deadbeef", b1.ramaddr, b1.ramstore); end
      total++; if (b1.dwait !== 2'b00 || b1.iwait !== 2'b01) begin bad++; $display("FAIL wr_waits: got d=%b i=%b exp 00 01", b1.dwait, b1.iwait); end
      total++; if (b1.dload[31:0] !== 32'h0) begin bad++; $display("FAIL wr_no_load: got %h exp 0", b1.dload[31:0]); end
      cyc(); b1.dWEN = 2'b00; b1.ramload = 32'h11112222;
      smp();
      total++; if (b1.iwait !== 2'b01 || b1.ramREN !== 1'b0) begin bad++; $display("FAIL wr_then_idle: got iwait=%b ren=%b exp 01 0", b1.iwait, b1.ramREN); end
      cyc();
      smp();
      total++; if (b1.ramREN !== 1'b1 || b1.ramaddr !== 32'h44 || b1.ramstore !== 32'h0) begin bad++; $display("FAIL wr_then_fetch: got ren=%b addr=%h st=%h exp 1 44 0", b1.ramREN, b1.ramaddr, b1.ramstore); end
      total++; if (b1.iwait !== 2'b00 || b1.iload[31:0] !== 32'h11112222) begin bad++; $display("FAIL wr_fetch_done: got %b/%h exp 00/11112222", b1.iwait, b1.iload[31:0]); end
      cyc(); b1.iREN = 2'b00; b1.ramstate = FREE;
      smp();
   endtask

   task automatic test_round_robin();
      int served[2];
      int exp_c;
      logic [31:0] ld;
      served[0] = 0; served[1] = 0;
      cyc(); b1.dREN = 2'b11; b1.daddr = {32'h200, 32'h100}; b1.ramstate = ACCESS;
      for (int t = 0; t < 20; t++) begin
         if (t > 0) cyc();
         b1.ramload = $urandom;
         smp();
         total++; if (b1.ramREN !== 1'b0 || b1.dwait !== 2'b11) begin bad++; $display("FAIL rr_idle_%0d: got ren=%b dwait=%b exp 0 11", t, b1.ramREN, b1.dwait); end
         cyc();
         ld = $urandom;
         b1.ramload = ld;
         exp_c = (t + 1) % 2;
         smp();
         total++; if (b1.ramREN !== 1'b1 || b1.ramaddr !== (exp_c == 1 ? 32'h200 : 32'h100)) begin bad++; $display("FAIL rr_addr_%0d: got ren=%b addr=%h exp core %0d", t, b1.ramREN, b1.ramaddr, exp_c); end
         total++; if (b1.dwait !== (exp_c == 1 ? 2'b01 : 2'b10)) begin bad++; $display("FAIL rr_wait_%0d: got %b exp core %0d done", t, b1.dwait, exp_c); end
         total++; if (b1.dload[32*exp_c +: 32] !== ld) begin bad++; $display("FAIL rr_load_%0d: got %h exp %h", t, b1.dload[32*exp_c +: 32], ld); end
         if (b1.dwait == 2'b10) served[0]++;
         if (b1.dwait == 2'b01) served[1]++;
         if (exp_c == 0) exp_dl0 = ld; else exp_dl1 = ld;
      end
      total++; if (served[0] != 10 || served[1] != 10) begin bad++; $display("FAIL rr_fairness: got %0d/%0d exp 10/10", served[0], served[1]); end
      cyc(); b1.dREN = 2'b00; b1.ramstate = FREE;
      smp();
      total++; if (b1.dload !== {exp_dl1, exp_dl0}) begin bad++; $display("FAIL rr_hold: got %h exp %h", b1.dload, {exp_dl1, exp_dl0}); end
   endtask

   task automatic test_error_retry();
      cyc(); b1.dREN = 2'b01; b1.daddr[31:0] = 32'h300; b1.ramstate = ERROR;
      smp();
      total++; if (b1.ramREN !== 1'b0) begin bad++; $display("FAIL err_idle: got ren=%b exp 0", b1.ramREN); end
      for (int i = 0; i < 3; i++) begin
         cyc();
         smp();
         total++; if (b1.ramREN !== 1'b1 || b1.ramaddr !== 32'h300 || b1.dwait !== 2'b01) begin bad++; $display("FAIL err_hold_%0d: got ren=%b addr=%h dwait=%b exp 1 300 01", i, b1.ramREN, b1.ramaddr, b1.dwait); end
         total++; if (b1.dload[31:0] !== exp_dl0) begin bad++; $display("FAIL err_load_%0d: got %h exp %h", i, b1.dload[31:0], exp_dl0); end
      end
      cyc(); b1.ramstate = ACCESS; b1.ramload = 32'h12345678;
      smp();
      total++; if (b1.dwait !== 2'b00 || b1.dload[31:0] !== 32'h12345678) begin bad++; $display("FAIL err_done: got %b/%h exp 00/12345678", b1.dwait, b1.dload[31:0]); end
      cyc(); b1.dREN = 2'b00; b1.ramstate = FREE;
      smp();
      total++; if (b1.dload[31:0] !== 32'h12345678 || b1.ramREN !== 1'b0) begin bad++; $display("FAIL err_after: got %h ren=%b exp 12345678 0", b1.dload[31:0], b1.ramREN); end
      exp_dl0 = 32'h12345678;
   endtask

   task automatic test_error_noretry();
      cyc(); b2.dREN = 2'b10; b2.daddr[63:32] = 32'h700; b2.ramstate = ERROR; b2.ramload = 32'h5555AAAA;
      smp();
      total++; if (b2.ramREN !== 1'b0 || b2.dwait !== 2'b10) begin bad++; $display("FAIL noretry_idle: got ren=%b dwait=%b exp 0 10", b2.ramREN, b2.dwait); end
      cyc();
      smp();
      total++; if (b2.ramREN !== 1'b1 || b2.ramaddr !== 32'h700) begin bad++; $display("FAIL noretry_drive: got ren=%b addr=%h exp 1 700", b2.ramREN, b2.ramaddr); end
      total++; if (b2.dwait !== 2'b00 || b2.dload[63:32] !== ARB_ERR_WORD) begin bad++; $display("FAIL noretry_done: got %b/%h exp 00/bad1bad1", b2.dwait, b2.dload[63:32]); end
      cyc(); b2.dREN = 2'b00; b2.ramstate = FREE;
      smp();
      total++; if (b2.dload[63:32] !== ARB_ERR_WORD || st2 !== ARB_IDLE || r2 !== 1'b0) begin bad++; $display("FAIL noretry_after: got %h st=%0d rr=%0d exp bad1bad1 0 0", b2.dload[63:32], st2, r2); end
   endtask

   task automatic test_abort();
      cyc(); b1.dREN = 2'b10; b1.daddr[63:32] = 32'h500; b1.ramstate = BUSY;
      smp();
      cyc();
      smp();
      total++; if (b1.ramREN !== 1'b1 || b1.ramaddr !== 32'h500 || b1.dwait !== 2'b10) begin bad++; $display("FAIL abort_grant: got ren=%b addr=%h dwait=%b exp 1 500 10", b1.ramREN, b1.ramaddr, b1.dwait); end
      cyc(); b1.dREN = 2'b00;
      smp();
      total++; if (b1.ramREN !== 1'b0 || b1.dwait !== 2'b00 || st1 !== ARB_GRANT) begin bad++; $display("FAIL abort_drop: got ren=%b dwait=%b st=%0d exp 0 00 1", b1.ramREN, b1.dwait, st1); end
      total++; if (b1.dload[63:32] !== exp_dl1) begin bad++; $display("FAIL abort_load: got %h exp %h", b1.dload[63:32], exp_dl1); end
      cyc(); b1.dREN = 2'b11; b1.daddr = {32'h504, 32'h104}; b1.ramstate = ACCESS; b1.ramload = 32'h0BADF00D;
      smp();
      total++; if (st1 !== ARB_IDLE || r1 !== 1'b1 || b1.dwait !== 2'b11) begin bad++; $display("FAIL abort_idle: got st=%0d rr=%0d dwait=%b exp 0 1 11", st1, r1, b1.dwait); end
      cyc();
      smp();
      total++; if (b1.ramaddr !== 32'h504 || b1.dwait !== 2'b01 || b1.dload[63:32] !== 32'h0BADF00D) begin bad++; $display("FAIL abort_regrant: got addr=%h dwait=%b load=%h exp 504 01 0badf00d", b1.ramaddr, b1.dwait, b1.dload[63:32]); end
      cyc(); b1.dREN = 2'b00; b1.ramstate = FREE;
      smp();
   endtask

   task automatic test_reset_mid_grant();
      cyc(); b1.dWEN = 2'b01; b1.daddr[31:0] = 32'h600; b1.dstore[31:0] = 32'h55; b1.ramstate = BUSY;
      smp();
      cyc();
      smp();
      total++; if (b1.ramWEN !== 1'b1) begin bad++; $display("FAIL midrst_before: got wen=%b exp 1", b1.ramWEN); end
      #1 rst_n = 1'b0;
      #1;
      total++; if (b1.ramWEN !== 1'b0 || b1.dwait !== 2'b01) begin bad++; $display("FAIL midrst_async: got wen=%b dwait=%b exp 0 01", b1.ramWEN, b1.dwait); end
      total++; if (st1 !== ARB_IDLE || r1 !== 1'b0 || b1.iload[31:0] !== 32'h0) begin bad++; $display("FAIL midrst_regs: got st=%0d rr=%0d iload=%h exp 0 0 0", st1, r1, b1.iload[31:0]); end
      @(posedge clk);
      #3 rst_n = 1'b1;
      smp();
      total++; if (st1 !== ARB_IDLE || b1.ramWEN !== 1'b0) begin bad++; $display("FAIL midrst_release: got st=%0d wen=%b exp 0 0", st1, b1.ramWEN); end
      cyc(); b1.ramstate = ACCESS;
      smp();
      total++; if (b1.ramWEN !== 1'b1 || b1.ramaddr !== 32'h600 || b1.ramstore !== 32'h55 || b1.dwait !== 2'b00) begin bad++; $display("FAIL midrst_regrant: got wen=%b addr=%h st=%h dwait=%b exp 1 600 55 00", b1.ramWEN, b1.ramaddr, b1.ramstore, b1.dwait); end
      cyc(); b1.dWEN = 2'b00; b1.ramstate = FREE;
      smp();
   endtask

   task automatic test_random();
      int m_busy, m_core, m_kind, m_ptr, w;
      logic [1:0] i_on, d_on, d_wr, drop_i, drop_d;
      logic [31:0] exp_il[2], exp_dl[2];
      logic e_ren, e_wen;
      logic [31:0] e_addr, e_store;
      logic [1:0] e_iwait, e_dwait;
      cyc(); clear_inputs(); rst_n = 1'b0;
      #2 rst_n = 1'b1;
      m_busy = 0; m_core = 0; m_kind = 0; m_ptr = 0;
      i_on = '0; d_on = '0; d_wr = '0; drop_i = '0; drop_d = '0;
      exp_il[0] = '0; exp_il[1] = '0; exp_dl[0] = '0; exp_dl[1] = '0;
      exp_q.delete();
      for (int n = 0; n < 400; n++) begin
         cyc();
         i_on = i_on & ~drop_i;
         d_on = d_on & ~drop_d;
         drop_i = '0; drop_d = '0;
         for (int c = 0; c < 2; c++) begin
            if (!i_on[c] && $urandom_range(0, 3) == 0) begin
               i_on[c] = 1'b1; b1.iaddr[32*c +: 32] = $urandom;
            end
            if (!d_on[c] && $urandom_range(0, 3) == 0) begin
               d_on[c] = 1'b1; d_wr[c] = 1'($urandom_range(0, 1));
               b1.daddr[32*c +: 32] = $urandom; b1.dstore[32*c +: 32] = $urandom;
            end
         end
         b1.iREN = i_on; b1.dREN = d_on & ~d_wr; b1.dWEN = d_on & d_wr;
         b1.ramstate = ramstate_t'($urandom_range(0, 3));
         b1.ramload = $urandom;
         smp();
         e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
         e_iwait = i_on; e_dwait = d_on;
         if (m_busy != 0) begin
            e_addr = exp_q[0];
            e_ren = (m_kind != 3); e_wen = (m_kind == 3);
            if (m_kind == 3) e_store = b1.dstore[32*m_core +: 32];
            if (b1.ramstate == ACCESS) begin
               if (m_kind == 1) begin e_iwait[m_core] = 1'b0; exp_il[m_core] = b1.ramload; drop_i[m_core] = 1'b1; end
               else begin e_dwait[m_core] = 1'b0; drop_d[m_core] = 1'b1; end
               if (m_kind == 2) exp_dl[m_core] = b1.ramload;
               m_ptr = (m_core + 1) % 2;
               m_busy = 0;
               void'(exp_q.pop_front());
            end
         end else begin
            w = pick(m_ptr, i_on | d_on);
            if (w >= 0) begin
               m_busy = 1; m_core = w;
               m_kind = d_on[w] ? (d_wr[w] ? 3 : 2) : 1;
               exp_q.push_back(m_kind == 1 ? b1.iaddr[32*w +: 32] : b1.daddr[32*w +: 32]);
            end
         end
         total++; if (b1.ramREN !== e_ren || b1.ramWEN !== e_wen) begin bad++; $display("FAIL rnd_en_%0d: got %b%b exp %b%b", n, b1.ramREN, b1.ramWEN, e_ren, e_wen); end
         total++; if (b1.ramaddr !== e_addr) begin bad++; $display("FAIL rnd_addr_%0d: got %h exp %h", n, b1.ramaddr, e_addr); end
         total++; if (b1.ramstore !== e_store) begin bad++; $display("FAIL rnd_store_%0d: got %h exp %h", n, b1.ramstore, e_store); end
         total++; if (b1.iwait !== e_iwait || b1.dwait !== e_dwait) begin bad++; $display("FAIL rnd_wait_%0d: got i=%b d=%b exp i=%b d=%b", n, b1.iwait, b1.dwait, e_iwait, e_dwait); end
         total++; if (b1.iload !== {exp_il[1], exp_il[0]}) begin bad++; $display("FAIL rnd_iload_%0d: got %h exp %h", n, b1.iload, {exp_il[1], exp_il[0]}); end
         total++; if (b1.dload !== {exp_dl[1], exp_dl[0]}) begin bad++; $display("FAIL rnd_dload_%0d: got %h exp %h", n, b1.dload, {exp_dl[1], exp_dl[0]}); end
      end
   endtask

   initial begin
      clear_inputs();
      exp_dl0 = '0;
      exp_dl1 = '0;
      test_reset();
      test_single_fetch();
      test_write_priority();
      test_round_robin();
      test_error_retry();
      test_error_noretry();
      test_abort();
      test_reset_mid_grant();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
